// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl: stall requests and
// branch redirect in, stall/flush/redirect controls and performance counters out.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [3:0]  stall_o;
    logic [1:0]  flush_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    // Pipeline side: raises requests, consumes controls.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_flag_i, branch_target_i,
        input  stall_o, flush_o, new_pc_valid_o, new_pc_o,
        input  stall_cnt_o, flush_cnt_o
    );

    // Controller side.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_flag_i, branch_target_i,
        output stall_o, flush_o, new_pc_valid_o, new_pc_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: merges stall requests, accepts EX redirects,
// flushes wrong-path stages, holds a pending target while the PC is stalled.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic        w_accept;
    logic [3:0]  w_stall_lvl;
    logic [3:0]  w_stall;
    logic [1:0]  w_flush;
    logic        w_npv;
    logic [31:0] w_npc;
    logic        w_load_pend;

    // A redirect from EX is only trusted when neither EX nor MEM is holding.
    assign w_accept = bus.branch_flag_i & ~bus.stallreq_ex & ~bus.stallreq_mem;

    always_comb begin
        w_stall_lvl = '0;
        if (bus.stallreq_mem) begin
            w_stall_lvl = 4'b1111;
        end else if (bus.stallreq_ex) begin
            w_stall_lvl = 4'b0111;
        end else if (bus.stallreq_id) begin
            w_stall_lvl = 4'b0011;
        end else if (bus.stallreq_if) begin
            w_stall_lvl = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stall[0] && (w_accept || r_state == ST_REDIRECT)) begin
            w_state_nxt = ST_REDIRECT;
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    // An accepted branch cancels an id-level stall: the hazarding instruction is wrong-path.
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        w_npv   = 1'b0;
        w_npc   = '0;
        if (!rst) begin
            if (w_accept) begin
                w_stall = bus.stallreq_if ? 4'b0001 : 4'b0000;
            end else begin
                w_stall = w_stall_lvl;
            end
            case (r_state)
                ST_RUN: begin
                    w_flush = {w_accept, w_accept};
                    w_npv   = w_accept;
                    w_npc   = w_accept ? bus.branch_target_i : '0;
                end
                ST_REDIRECT: begin
                    w_flush = {w_accept, 1'b1};
                    w_npv   = 1'b1;
                    w_npc   = w_accept ? bus.branch_target_i : r_pend_pc;
                end
                default: begin
                    w_flush = '0;
                end
            endcase
        end
    end

    assign w_load_pend = w_accept & w_stall[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_pc   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_load_pend) begin
                r_pend_pc <= bus.branch_target_i;
            end
            if (|w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.flush_o        = w_flush;
    assign bus.new_pc_valid_o = w_npv;
    assign bus.new_pc_o       = w_npc;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.flush_cnt_o    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step drives inputs, checks the combinational
// controls, clocks once, then checks both counters against hand-tracked values.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] exp_sc;
    logic [31:0] exp_fc;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: drive, check comb outputs, clock, check counters.
    task automatic step(input string nm, input bit r, input bit sif, input bit sid,
                        input bit sex, input bit smem, input bit br, input logic [31:0] tgt,
                        input logic [3:0] es, input logic [1:0] ef, input bit ev,
                        input logic [31:0] epc);
        rst                 = r;
        bus.stallreq_if     = sif;
        bus.stallreq_id     = sid;
        bus.stallreq_ex     = sex;
        bus.stallreq_mem    = smem;
        bus.branch_flag_i   = br;
        bus.branch_target_i = tgt;
        #1;
        chk({nm, ".stall"}, {28'd0, bus.stall_o}, {28'd0, es});
        chk({nm, ".flush"}, {30'd0, bus.flush_o}, {30'd0, ef});
        chk({nm, ".npv"},   {31'd0, bus.new_pc_valid_o}, {31'd0, ev});
        chk({nm, ".npc"},   bus.new_pc_o, epc);
        @(posedge clk);
        #1;
        if (r) begin
            exp_sc = '0;
            exp_fc = '0;
        end else begin
            if (es != 4'b0000) exp_sc = exp_sc + 32'd1;
            if (ef[1])         exp_fc = exp_fc + 32'd1;
        end
        chk({nm, ".stall_cnt"}, bus.stall_cnt_o, exp_sc);
        chk({nm, ".flush_cnt"}, bus.flush_cnt_o, exp_fc);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        exp_sc = '0;
        exp_fc = '0;
        //    name      rst if id ex mem br target        stall    flush  npv pc
        step("rst0",    1, 0, 0, 0, 1,  1, 32'h0000_0ABC, 4'b0000, 2'b00, 0, 32'h0);
        step("rst1",    1, 1, 0, 0, 0,  1, 32'h0000_0123, 4'b0000, 2'b00, 0, 32'h0);
        step("idle",    0, 0, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b00, 0, 32'h0);
        step("s_if",    0, 1, 0, 0, 0,  0, 32'h0,         4'b0001, 2'b00, 0, 32'h0);
        step("s_id",    0, 0, 1, 0, 0,  0, 32'h0,         4'b0011, 2'b00, 0, 32'h0);
        step("s_ex",    0, 0, 0, 1, 0,  0, 32'h0,         4'b0111, 2'b00, 0, 32'h0);
        step("s_mem",   0, 0, 0, 0, 1,  0, 32'h0,         4'b1111, 2'b00, 0, 32'h0);
        step("s_all",   0, 1, 1, 1, 1,  0, 32'h0,         4'b1111, 2'b00, 0, 32'h0);
        step("s_ifid",  0, 1, 1, 0, 0,  0, 32'h0,         4'b0011, 2'b00, 0, 32'h0);
        // Plain branch, no stalls: one-cycle redirect, stays in RUN.
        step("br100",   0, 0, 0, 0, 0,  1, 32'h0000_0100, 4'b0000, 2'b11, 1, 32'h100);
        step("br100_n", 0, 0, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b00, 0, 32'h0);
        // Branch while fetch stalls: REDIRECT holds 0x200 until PC is free.
        step("br200",   0, 1, 0, 0, 0,  1, 32'h0000_0200, 4'b0001, 2'b11, 1, 32'h200);
        step("rd200_1", 0, 1, 0, 0, 0,  0, 32'h0,         4'b0001, 2'b01, 1, 32'h200);
        step("rd200_2", 0, 1, 0, 0, 0,  0, 32'h0,         4'b0001, 2'b01, 1, 32'h200);
        step("rd200_3", 0, 0, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b01, 1, 32'h200);
        step("run_aft", 0, 0, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b00, 0, 32'h0);
        // Branch blocked by EX busy, then accepted once EX releases.
        step("brex_1",  0, 0, 0, 1, 0,  1, 32'h0000_0300, 4'b0111, 2'b00, 0, 32'h0);
        step("brex_2",  0, 0, 0, 1, 0,  1, 32'h0000_0300, 4'b0111, 2'b00, 0, 32'h0);
        step("brex_3",  0, 0, 0, 0, 0,  1, 32'h0000_0300, 4'b0000, 2'b11, 1, 32'h300);
        // Load-use stall cancelled by the branch.
        step("brid",    0, 0, 1, 0, 0,  1, 32'h0000_0400, 4'b0000, 2'b11, 1, 32'h400);
        step("brmem",   0, 1, 0, 0, 1,  1, 32'h0000_0440, 4'b1111, 2'b00, 0, 32'h0);
        step("bridif",  0, 1, 1, 0, 0,  1, 32'h0000_0480, 4'b0001, 2'b11, 1, 32'h480);
        step("rd480_x", 0, 0, 0, 1, 0,  0, 32'h0,         4'b0111, 2'b01, 1, 32'h480);
        step("rd480_e", 0, 0, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b01, 1, 32'h480);
        // Second branch in REDIRECT overwrites the pending target.
        step("br500",   0, 1, 0, 0, 0,  1, 32'h0000_0500, 4'b0001, 2'b11, 1, 32'h500);
        step("br600",   0, 1, 0, 0, 0,  1, 32'h0000_0600, 4'b0001, 2'b11, 1, 32'h600);
        step("rd600",   0, 1, 0, 0, 0,  0, 32'h0,         4'b0001, 2'b01, 1, 32'h600);
        // Reset during REDIRECT drops the pending target and clears counters.
        step("rst_rd",  1, 1, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b00, 0, 32'h0);
        step("post_r",  0, 0, 0, 0, 0,  0, 32'h0,         4'b0000, 2'b00, 0, 32'h0);
        step("post_if", 0, 1, 0, 0, 0,  0, 32'h0,         4'b0001, 2'b00, 0, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
